// File: rtl/burst_sram_pkg.sv
// Shared defaults and the controller state type for the burst SRAM.
package burst_sram_pkg;

   localparam int DEF_ADDR_WIDTH = 6;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_LEN_WIDTH  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_e;

endpackage

// File: rtl/burst_addr_gen.sv
// Next-address logic for incrementing and wrapping bursts.
// A wrapping burst stays inside the (len+1)-aligned block holding the start
// address; if len+1 is not a power of two the burst simply increments.
module burst_addr_gen #(
   parameter int ADDR_WIDTH = 6,
   parameter int LEN_WIDTH  = 4
) (
   input  logic [ADDR_WIDTH-1:0] cur_addr,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic                  wrap,
   output logic [ADDR_WIDTH-1:0] next_addr
);

   logic [LEN_WIDTH:0]    len_ext;
   logic [LEN_WIDTH:0]    len_p1;
   logic [ADDR_WIDTH-1:0] mask;
   logic [ADDR_WIDTH-1:0] incr;
   logic                  is_pow2;

   // A power-of-two block of len+1 words means len is an all-ones low mask.
   if (LEN_WIDTH < ADDR_WIDTH) begin : g_mask_pad
      assign mask = {{(ADDR_WIDTH-LEN_WIDTH){1'b0}}, len};
   end else begin : g_mask_trunc
      assign mask = len[ADDR_WIDTH-1:0];
   end

   // Pick the wrapped or plain-incremented successor address.
   always_comb begin
      len_ext = {1'b0, len};
      len_p1  = len_ext + (LEN_WIDTH+1)'(1);
      is_pow2 = ((len_ext & len_p1) == '0);
      incr    = cur_addr + ADDR_WIDTH'(1);
      if (wrap && is_pow2) begin
         next_addr = (start_addr & ~mask) | (incr & mask);
      end else begin
         next_addr = incr;
      end
   end

endmodule

// File: rtl/burst_sram.sv
// Single-port word SRAM with a burst command front end.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, data is held while valid && !ready.
// A write burst takes len+1 beats on wr_*; a read burst returns len+1 beats on
// rd_* through one output register, rd_last marking the final beat.
module burst_sram
   import burst_sram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [LEN_WIDTH-1:0]    cmd_len,
   input  logic                    cmd_wrap,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_last,
   output logic                    busy,
   output state_e                  state_dbg
);

   localparam int DEPTH  = 2**ADDR_WIDTH;
   localparam int NBYTES = DATA_WIDTH/8;

   state_e                state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  cnt;
   logic                  wrap_q;
   logic                  rst_done;
   logic                  last_beat;
   logic                  wr_fire;
   logic                  rd_load;

   // rst_done keeps cmd_ready low until the first clock edge after reset.
   assign cmd_ready = rst_done && (state == IDLE) && !rd_valid;
   assign wr_ready  = (state == WRITE);
   assign wr_fire   = wr_valid && wr_ready;
   assign rd_load   = (state == READ) && (!rd_valid || rd_ready);
   assign last_beat = (cnt == len_q);
   assign busy      = (state != IDLE) || rd_valid;
   assign state_dbg = state;

   burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) u_addr_gen (
      .cur_addr   (cur_addr),
      .start_addr (start_addr),
      .len        (len_q),
      .wrap       (wrap_q),
      .next_addr  (next_addr)
   );

   // Storage: cleared by reset, byte-masked update on every accepted write beat.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_fire) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (wr_be[b]) begin
               mem[cur_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Burst controller: command capture, beat counting and the read output register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         cur_addr   <= '0;
         start_addr <= '0;
         len_q      <= '0;
         cnt        <= '0;
         wrap_q     <= 1'b0;
         rst_done   <= 1'b0;
         rd_valid   <= 1'b0;
         rd_last    <= 1'b0;
         rd_data    <= '0;
      end else begin
         rst_done <= 1'b1;
         case (state)
            IDLE: begin
               // The final read beat may still be waiting to be consumed here.
               if (rd_valid && rd_ready) begin
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
               end
               if (cmd_valid && cmd_ready) begin
                  start_addr <= cmd_addr;
                  cur_addr   <= cmd_addr;
                  len_q      <= cmd_len;
                  wrap_q     <= cmd_wrap;
                  cnt        <= '0;
                  state      <= cmd_write ? WRITE : READ;
               end
            end
            WRITE: begin
               if (wr_fire) begin
                  cur_addr <= next_addr;
                  cnt      <= cnt + LEN_WIDTH'(1);
                  if (last_beat) state <= IDLE;
               end
            end
            READ: begin
               if (rd_load) begin
                  rd_data  <= mem[cur_addr];
                  rd_valid <= 1'b1;
                  rd_last  <= last_beat;
                  cur_addr <= next_addr;
                  cnt      <= cnt + LEN_WIDTH'(1);
                  if (last_beat) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_sram.sv
// Self-checking bench for burst_sram: directed scenarios plus random bursts
// compared against a word-array model of the memory.
module tb_burst_sram;
   import burst_sram_pkg::*;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int LW    = 4;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rstn;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          cmd_wrap = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic [DW/8-1:0] wr_be = '0;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_last;
   logic          busy;
   state_e        state_dbg;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0]   model_mem [DEPTH];
   logic [DW-1:0]   exp_q [$];
   logic [DW-1:0]   got_q [$];
   logic [DW-1:0]   wd [16];
   logic [DW/8-1:0] wb [16];

   // clock / reset block
   always #5 clk = ~clk;

   burst_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_wrap  (cmd_wrap),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .wr_be     (wr_be),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // Address of beat i of a burst, from the burst rules directly.
   function automatic int beat_addr(int start, int len, bit wp, int i);
      int n;
      int base;
      n = len + 1;
      if (wp && ((n & (n - 1)) == 0)) begin
         base = (start / n) * n;
         return base + ((start - base + i) % n);
      end
      return (start + i) % DEPTH;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
   endtask

   // driver: offer a command and return at the negedge after it is accepted
   task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic wp);
      int t;
      t = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
      cmd_wrap  = wp;
      while (!cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_accept: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_len   = LW'($urandom);
      cmd_wrap  = 1'($urandom);
   endtask

   // driver: write burst using wd/wb, optional random wr_valid gaps
   task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic wp,
                           input bit stall);
      int i;
      int t;
      int ready_bad;
      int ad;
      i = 0;
      t = 0;
      ready_bad = 0;
      send_cmd(1'b1, a, l, wp);
      while (i <= int'(l) && t < 200) begin
         if (wr_ready !== 1'b1) ready_bad++;
         if (stall && $urandom_range(0, 2) == 0) begin
            wr_valid = 1'b0;
            wr_data  = $urandom;
            wr_be    = 4'($urandom);
         end else begin
            wr_valid = 1'b1;
            wr_data  = wd[i];
            wr_be    = wb[i];
            ad = beat_addr(int'(a), int'(l), wp, i);
            for (int b = 0; b < DW/8; b++) begin
               if (wb[i][b]) model_mem[ad][8*b +: 8] = wd[i][8*b +: 8];
            end
            i++;
         end
         @(negedge clk);
         t++;
      end
      wr_valid = 1'b0;
      checks++;
      if (ready_bad != 0) begin
         errors++;
         $display("FAIL wr_ready_during_burst: low on %0d cycles, required 0", ready_bad);
      end
      checks++;
      if (wr_ready !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL write_end: wr_ready=%b busy=%b cmd_ready=%b required 0 0 1",
                  wr_ready, busy, cmd_ready);
      end
   endtask

   // driver + scoreboard: read burst; mode 0 ready held, 1 toggled, 2 random
   task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic wp,
                          input int mode);
      int got;
      int cyc;
      int gaps;
      int stall_bad;
      int crdy_bad;
      int busy_bad;
      bit was_stalled;
      bit r;
      logic [DW-1:0] held;
      logic held_last;
      got = 0;
      cyc = 0;
      gaps = 0;
      stall_bad = 0;
      crdy_bad = 0;
      busy_bad = 0;
      was_stalled = 1'b0;
      held = '0;
      held_last = 1'b0;
      exp_q.delete();
      got_q.delete();
      for (int i = 0; i <= int'(l); i++) exp_q.push_back(model_mem[beat_addr(int'(a), int'(l), wp, i)]);
      send_cmd(1'b0, a, l, wp);
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_valid_early: rd_valid=%b required 0 half a cycle after accept", rd_valid);
      end
      while (got <= int'(l) && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            checks++;
            if (rd_valid !== 1'b1) begin
               errors++;
               $display("FAIL rd_first_latency: rd_valid=%b required 1 one cycle after accept", rd_valid);
            end
         end
         r = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 1) : 1'($urandom_range(0, 1));
         rd_ready = r;
         if (cmd_ready !== 1'b0) crdy_bad++;
         if (busy !== 1'b1) busy_bad++;
         if (rd_valid !== 1'b1) begin
            gaps++;
         end else begin
            if (was_stalled && (rd_data !== held || rd_last !== held_last)) stall_bad++;
            if (r) begin
               got_q.push_back(rd_data);
               checks++;
               if (rd_data !== exp_q[got]) begin
                  errors++;
                  $display("FAIL rd_data beat %0d: got %h expected %h", got, rd_data, exp_q[got]);
               end
               checks++;
               if (rd_last !== (got == int'(l))) begin
                  errors++;
                  $display("FAIL rd_last beat %0d: got %b expected %b", got, rd_last, got == int'(l));
               end
               got++;
               was_stalled = 1'b0;
            end else begin
               was_stalled = 1'b1;
               held = rd_data;
               held_last = rd_last;
            end
         end
      end
      checks++;
      if (got != int'(l) + 1) begin
         errors++;
         $display("FAIL rd_beat_count: got %0d beats expected %0d", got, int'(l) + 1);
      end
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("FAIL rd_stall_hold: %0d unstable stalled cycles, required 0", stall_bad);
      end
      checks++;
      if (crdy_bad != 0 || busy_bad != 0) begin
         errors++;
         $display("FAIL rd_busy_phase: cmd_ready high %0d, busy low %0d cycles, required 0 0",
                  crdy_bad, busy_bad);
      end
      if (mode == 0) begin
         checks++;
         if (gaps != 0) begin
            errors++;
            $display("FAIL rd_back_to_back: %0d gap cycles, required 0", gaps);
         end
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL read_end: rd_valid=%b cmd_ready=%b busy=%b required 0 1 0",
                  rd_valid, cmd_ready, busy);
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      #1 rstn = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== '0 || busy !== 1'b0 ||
          cmd_ready !== 1'b0 || wr_ready !== 1'b0 || state_dbg !== IDLE) begin
         errors++;
         $display("FAIL reset_outputs: rd_valid=%b rd_last=%b rd_data=%h busy=%b cmd_ready=%b wr_ready=%b state=%0d required all 0",
                  rd_valid, rd_last, rd_data, busy, cmd_ready, wr_ready, state_dbg);
      end
      rstn = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL cmd_ready_before_edge: got %b required 0", cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready_after_release: got %b required 1", cmd_ready);
      end
   endtask

   task automatic test_incr_basic();
      for (int i = 0; i < 4; i++) begin
         wd[i] = 32'hA0 + i;
         wb[i] = 4'hF;
      end
      do_write(6'h04, 4'd3, 1'b0, 1'b0);
      do_read(6'h04, 4'd3, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_q.size() != 4 || got_q[i] !== 32'hA0 + i) begin
            errors++;
            $display("FAIL incr_basic beat %0d: got %h expected %h", i, got_q[i], 32'hA0 + i);
         end
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) begin
         wd[i] = 32'hB0 + i;
         wb[i] = 4'hF;
      end
      do_write(6'h06, 4'd3, 1'b1, 1'b1);
      do_read(6'h04, 4'd3, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_q[i] !== 32'hB0 + ((i + 2) % 4)) begin
            errors++;
            $display("FAIL wrap_order word %0d: got %h expected %h", 4 + i, got_q[i], 32'hB0 + ((i + 2) % 4));
         end
      end
      do_read(6'h06, 4'd3, 1'b1, 2);
   endtask

   task automatic test_top_rollover();
      for (int i = 0; i < 4; i++) begin
         wd[i] = 32'hC0 + i;
         wb[i] = 4'hF;
      end
      do_write(6'h3E, 4'd3, 1'b0, 1'b0);
      do_read(6'h00, 4'd1, 1'b0, 0);
      checks++;
      if (got_q[0] !== 32'hC2 || got_q[1] !== 32'hC3) begin
         errors++;
         $display("FAIL top_rollover: got %h %h expected c2 c3", got_q[0], got_q[1]);
      end
      do_read(6'h3E, 4'd3, 1'b0, 0);
   endtask

   task automatic test_byte_enable();
      wd[0] = 32'h11223344;
      wb[0] = 4'hF;
      do_write(6'h10, 4'd0, 1'b0, 1'b0);
      wd[0] = 32'hAABBCCDD;
      wb[0] = 4'h5;
      do_write(6'h10, 4'd0, 1'b0, 1'b0);
      do_read(6'h10, 4'd0, 1'b0, 0);
      checks++;
      if (got_q[0] !== 32'h11BB33DD) begin
         errors++;
         $display("FAIL byte_enable: got %h expected 11bb33dd", got_q[0]);
      end
   endtask

   task automatic test_stalled_read();
      for (int i = 0; i < 8; i++) begin
         wd[i] = $urandom;
         wb[i] = 4'hF;
      end
      do_write(6'h20, 4'd7, 1'b0, 1'b1);
      do_read(6'h20, 4'd7, 1'b0, 1);
   endtask

   task automatic test_ignore_inputs();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         wr_valid = 1'b1;
         wr_data  = $urandom;
         wr_be    = 4'hF;
         rd_ready = 1'($urandom);
         checks++;
         if (wr_ready !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: wr_ready=%b rd_valid=%b required 0 0", wr_ready, rd_valid);
         end
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      do_read(6'h00, 4'd15, 1'b0, 2);
      do_read(6'h10, 4'd15, 1'b0, 0);
   endtask

   task automatic test_back_to_back_random();
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      logic wp;
      for (int n = 0; n < 30; n++) begin
         a  = AW'($urandom);
         l  = LW'($urandom);
         wp = 1'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 16; i++) begin
               wd[i] = $urandom;
               wb[i] = 4'($urandom);
            end
            do_write(a, l, wp, 1'($urandom));
         end else begin
            do_read(a, l, wp, $urandom_range(0, 2));
         end
      end
   endtask

   task automatic test_mid_burst_reset();
      for (int i = 0; i < 8; i++) wd[i] = $urandom | 32'h1;
      send_cmd(1'b1, 6'h08, 4'd7, 1'b0);
      for (int i = 0; i < 2; i++) begin
         wr_valid = 1'b1;
         wr_data  = wd[i];
         wr_be    = 4'hF;
         @(negedge clk);
      end
      wr_valid = 1'b1;
      wr_data  = wd[2];
      #2 rstn = 1'b0;
      model_clear();
      #1;
      checks++;
      if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== '0 || busy !== 1'b0 ||
          cmd_ready !== 1'b0 || wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: rd_valid=%b rd_last=%b rd_data=%h busy=%b cmd_ready=%b wr_ready=%b required all 0",
                  rd_valid, rd_last, rd_data, busy, cmd_ready, wr_ready);
      end
      wr_valid = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
      end
      for (int k = 0; k < 4; k++) do_read(AW'(k * 16), 4'd15, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_incr_basic();
      test_wrap();
      test_top_rollover();
      test_byte_enable();
      test_stalled_read();
      test_ignore_inputs();
      test_back_to_back_random();
      test_mid_burst_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
